// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: FSM state encoding and next-PC select.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_EXC  = 3'd5,
        SEL_HOLD = 3'd6
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage control/PC bundle between the pipeline (master) and pc_sequencer (slave).
// Optional return-address-stack signals are present only when PC_RAS_EN is defined.
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int BITS_SIZE = 32
);
    // No backpressure: every control input is sampled on each rising Clk edge and
    // every output is valid for the whole cycle; PCValid qualifies PCResult for fetch.
    logic                 Stall;
    logic                 BranchTaken;
    logic [BITS_SIZE-1:0] BranchOffset;
    logic                 JumpEn;
    logic [BITS_SIZE-1:0] JumpTarget;
    logic                 ExcEn;
    logic [BITS_SIZE-1:0] PCResult;
    logic [BITS_SIZE-1:0] PCPlus;
    logic                 PCValid;
    logic                 MisalignErr;
    pc_state_e            State;
`ifdef PC_RAS_EN
    logic                 CallEn;
    logic                 RetEn;
    logic                 RasEmpty;
    logic                 RasOverflow;

    modport master (
        output Stall, BranchTaken, BranchOffset, JumpEn, JumpTarget, ExcEn, CallEn, RetEn,
        input  PCResult, PCPlus, PCValid, MisalignErr, State, RasEmpty, RasOverflow
    );
    modport slave (
        input  Stall, BranchTaken, BranchOffset, JumpEn, JumpTarget, ExcEn, CallEn, RetEn,
        output PCResult, PCPlus, PCValid, MisalignErr, State, RasEmpty, RasOverflow
    );
`else
    modport master (
        output Stall, BranchTaken, BranchOffset, JumpEn, JumpTarget, ExcEn,
        input  PCResult, PCPlus, PCValid, MisalignErr, State
    );
    modport slave (
        input  Stall, BranchTaken, BranchOffset, JumpEn, JumpTarget, ExcEn,
        output PCResult, PCPlus, PCValid, MisalignErr, State
    );
`endif
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on full overwrites the oldest entry and sets
// a sticky overflow flag. Pop has priority over push.
module pc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic [PW:0]   count;
    logic          full;

    // ptr is the next write slot; the power-of-2 depth makes pointer wrap free
    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (pop) begin
            ptr   <= top_idx;
            count <= count - (PW+1)'(1);
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (full) overflow <= 1'b1;
            else      count    <= count + (PW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && !pop && push) mem[ptr] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with BOOT/RUN/TRAP sequencing, branch/jump/exception
// redirect and misalignment trapping. Define PC_RAS_EN to add the call/return stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                   BITS_SIZE    = 32,
    parameter logic [BITS_SIZE-1:0] RESET_VECTOR = '0,
    parameter logic [BITS_SIZE-1:0] EXC_VECTOR   = BITS_SIZE'('h80),
    parameter int                   INSTR_BYTES  = 4,
    parameter int                   RAS_DEPTH    = 4
) (
    input logic            Clk,
    input logic            Reset,
    pc_sequencer_if.slave  bus
);
    localparam logic [BITS_SIZE-1:0] STEP       = BITS_SIZE'(INSTR_BYTES);
    localparam logic [BITS_SIZE-1:0] ALIGN_MASK = BITS_SIZE'(INSTR_BYTES - 1);

    pc_state_e            state_q;
    logic [BITS_SIZE-1:0] pc_q;
    logic                 valid_q;
    logic                 misalign_q;

    pc_sel_e              sel;
    logic [BITS_SIZE-1:0] pc_plus;
    logic [BITS_SIZE-1:0] target;
    logic                 bad;

    assign pc_plus = pc_q + STEP;

`ifdef PC_RAS_EN
    logic [BITS_SIZE-1:0] ras_top;
    logic                 ras_empty;
    logic                 ras_overflow;
    logic                 ras_push;
    logic                 ras_pop;

    assign ras_push = (sel == SEL_CALL) && !bad;
    assign ras_pop  = (sel == SEL_RET)  && !bad;

    pc_ras #(.W(BITS_SIZE), .DEPTH(RAS_DEPTH)) u_ras (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow)
    );

    assign bus.RasEmpty    = ras_empty;
    assign bus.RasOverflow = ras_overflow;
`endif

    // Priority select; outside RUN only ExcEn is honoured, everything else holds.
    always_comb begin
        sel = SEL_HOLD;
        if (bus.ExcEn)                           sel = SEL_EXC;
        else if (state_q != ST_RUN || bus.Stall) sel = SEL_HOLD;
`ifdef PC_RAS_EN
        else if (bus.RetEn)                      sel = SEL_RET;
        else if (bus.CallEn)                     sel = SEL_CALL;
`endif
        else if (bus.JumpEn)                     sel = SEL_JMP;
        else if (bus.BranchTaken)                sel = SEL_BR;
        else                                     sel = SEL_SEQ;
    end

    always_comb begin
        target = pc_q;
        case (sel)
            SEL_SEQ:            target = pc_plus;
            SEL_BR:             target = pc_q + bus.BranchOffset;
            SEL_JMP, SEL_CALL:  target = bus.JumpTarget;
`ifdef PC_RAS_EN
            SEL_RET:            target = ras_top;
`endif
            default:            target = pc_q;
        endcase
    end

    // A pop from an empty stack is trapped the same way as a misaligned target.
    always_comb begin
        bad = ((sel == SEL_BR) || (sel == SEL_JMP) || (sel == SEL_CALL) || (sel == SEL_RET))
              && ((target & ALIGN_MASK) != '0);
`ifdef PC_RAS_EN
        if (sel == SEL_RET && ras_empty) bad = 1'b1;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bad;
            if (sel == SEL_EXC || bad) begin
                state_q <= ST_TRAP;
                pc_q    <= EXC_VECTOR;
                valid_q <= 1'b0;
            end else if (sel == SEL_HOLD) begin
                if (!bus.Stall && state_q != ST_RUN) begin
                    state_q <= ST_RUN;
                    valid_q <= 1'b1;
                end
            end else begin
                pc_q <= target;
            end
        end
    end

    assign bus.PCResult    = pc_q;
    assign bus.PCPlus      = pc_plus;
    assign bus.PCValid     = valid_q;
    assign bus.MisalignErr = misalign_q;
    assign bus.State       = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the return-stack scenario runs when PC_RAS_EN is defined.
module tb_pc_sequencer;
    import pc_pkg::*;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    pc_sequencer_if #(.BITS_SIZE(32)) bus ();

    pc_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchOffset = '0;
        bus.JumpEn       = 1'b0;
        bus.JumpTarget   = '0;
        bus.ExcEn        = 1'b0;
`ifdef PC_RAS_EN
        bus.CallEn       = 1'b0;
        bus.RetEn        = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        clear_inputs();
        Reset = 1'b1;
        step();
        step();
        total++;
        if (bus.PCResult !== 32'h0 || bus.PCValid !== 1'b0 || bus.MisalignErr !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: pc=%h valid=%b err=%b want pc=0 valid=0 err=0",
                     bus.PCResult, bus.PCValid, bus.MisalignErr);
        end
        total++;
        if (bus.State !== ST_BOOT) begin
            bad++;
            $display("FAIL reset_state: got %0d want %0d", bus.State, ST_BOOT);
        end
`ifdef PC_RAS_EN
        total++;
        if (bus.RasEmpty !== 1'b1 || bus.RasOverflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_ras: empty=%b ovf=%b want 1 0", bus.RasEmpty, bus.RasOverflow);
        end
`endif
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.PCResult !== exp_pc[i] || bus.PCValid !== 1'b1) begin
                bad++;
                $display("FAIL boot_seq[%0d]: pc=%h valid=%b want pc=%h valid=1",
                         i, bus.PCResult, bus.PCValid, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch_wrap();
        bus.BranchTaken  = 1'b1;
        bus.BranchOffset = 32'hFFFF_FFF8;
        step();
        clear_inputs();
        total++;
        if (bus.PCResult !== 32'h0) begin
            bad++;
            $display("FAIL branch_back: pc=%h want 00000000", bus.PCResult);
        end
        bus.JumpEn     = 1'b1;
        bus.JumpTarget = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        total++;
        if (bus.PCResult !== 32'hFFFF_FFFC || bus.PCPlus !== 32'h0) begin
            bad++;
            $display("FAIL jump_top: pc=%h plus=%h want fffffffc 00000000",
                     bus.PCResult, bus.PCPlus);
        end
        step();
        total++;
        if (bus.PCResult !== 32'h0 || bus.MisalignErr !== 1'b0 || bus.PCValid !== 1'b1) begin
            bad++;
            $display("FAIL seq_wrap: pc=%h err=%b valid=%b want 0 0 1",
                     bus.PCResult, bus.MisalignErr, bus.PCValid);
        end
    endtask

    task automatic test_stall();
        bus.JumpEn     = 1'b1;
        bus.JumpTarget = 32'h10;
        step();
        bus.Stall      = 1'b1;
        bus.JumpTarget = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.PCResult !== 32'h10 || bus.MisalignErr !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: pc=%h err=%b want 00000010 0",
                         i, bus.PCResult, bus.MisalignErr);
            end
        end
        bus.Stall = 1'b0;
        step();
        clear_inputs();
        total++;
        if (bus.PCResult !== 32'h40) begin
            bad++;
            $display("FAIL stall_release: pc=%h want 00000040", bus.PCResult);
        end
    endtask

    task automatic test_misalign();
        bus.JumpEn     = 1'b1;
        bus.JumpTarget = 32'h42;
        step();
        clear_inputs();
        total++;
        if (bus.MisalignErr !== 1'b1 || bus.PCResult !== 32'h80 || bus.PCValid !== 1'b0
            || bus.State !== ST_TRAP) begin
            bad++;
            $display("FAIL misalign_trap: err=%b pc=%h valid=%b st=%0d want 1 00000080 0 %0d",
                     bus.MisalignErr, bus.PCResult, bus.PCValid, bus.State, ST_TRAP);
        end
        step();
        total++;
        if (bus.MisalignErr !== 1'b0 || bus.PCResult !== 32'h80 || bus.PCValid !== 1'b1) begin
            bad++;
            $display("FAIL misalign_exit: err=%b pc=%h valid=%b want 0 00000080 1",
                     bus.MisalignErr, bus.PCResult, bus.PCValid);
        end
        step();
        total++;
        if (bus.PCResult !== 32'h84) begin
            bad++;
            $display("FAIL misalign_next: pc=%h want 00000084", bus.PCResult);
        end
    endtask

    task automatic test_exception();
        bus.ExcEn        = 1'b1;
        bus.Stall        = 1'b1;
        bus.BranchTaken  = 1'b1;
        bus.BranchOffset = 32'h20;
        step();
        clear_inputs();
        total++;
        if (bus.PCResult !== 32'h80 || bus.PCValid !== 1'b0 || bus.State !== ST_TRAP
            || bus.MisalignErr !== 1'b0) begin
            bad++;
            $display("FAIL exc_trap: pc=%h valid=%b st=%0d err=%b want 00000080 0 %0d 0",
                     bus.PCResult, bus.PCValid, bus.State, bus.MisalignErr, ST_TRAP);
        end
        // Jump request inside TRAP must be ignored
        bus.JumpEn     = 1'b1;
        bus.JumpTarget = 32'h200;
        step();
        clear_inputs();
        total++;
        if (bus.PCResult !== 32'h80 || bus.PCValid !== 1'b1 || bus.State !== ST_RUN) begin
            bad++;
            $display("FAIL exc_exit: pc=%h valid=%b st=%0d want 00000080 1 %0d",
                     bus.PCResult, bus.PCValid, bus.State, ST_RUN);
        end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [31:0] exp_q [$];
        logic [31:0] exp_ret;
        exp_q = {};
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(bus.PCResult + 32'h4);
            if (exp_q.size() > 4) void'(exp_q.pop_front());
            bus.CallEn     = 1'b1;
            bus.JumpTarget = 32'(i) << 8;
            step();
            clear_inputs();
            total++;
            if (bus.PCResult !== (32'(i) << 8)) begin
                bad++;
                $display("FAIL call[%0d]: pc=%h want %h", i, bus.PCResult, 32'(i) << 8);
            end
        end
        total++;
        if (bus.RasOverflow !== 1'b1 || bus.RasEmpty !== 1'b0) begin
            bad++;
            $display("FAIL ras_overflow: ovf=%b empty=%b want 1 0", bus.RasOverflow, bus.RasEmpty);
        end
        for (int i = 0; i < 4; i++) begin
            exp_ret    = exp_q.pop_back();
            bus.RetEn  = 1'b1;
            step();
            clear_inputs();
            total++;
            if (bus.PCResult !== exp_ret || bus.MisalignErr !== 1'b0) begin
                bad++;
                $display("FAIL ret[%0d]: pc=%h err=%b want %h 0",
                         i, bus.PCResult, bus.MisalignErr, exp_ret);
            end
        end
        total++;
        if (bus.RasEmpty !== 1'b1) begin
            bad++;
            $display("FAIL ras_empty: got %b want 1", bus.RasEmpty);
        end
        bus.RetEn = 1'b1;
        step();
        clear_inputs();
        total++;
        if (bus.MisalignErr !== 1'b1 || bus.PCResult !== 32'h80 || bus.PCValid !== 1'b0) begin
            bad++;
            $display("FAIL ret_empty: err=%b pc=%h valid=%b want 1 00000080 0",
                     bus.MisalignErr, bus.PCResult, bus.PCValid);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        clear_inputs();
        test_reset();
        test_branch_wrap();
        test_stall();
        test_misalign();
        test_exception();
`ifdef PC_RAS_EN
        test_ras();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
